// File: rtl/img_pkg.sv
// Shared definitions for the 3x3 window producer and the convolution consumer.
// Holds default frame geometry, the window index map (w[k], k = r*3+c,
// w0 = top-left, w8 = bottom-right) and the kernel weights, so both ends
// agree on the window ordering.
package img_pkg;

  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 512;
  localparam int DW_DEF    = 16;
  localparam int WIN_W     = 9 * DW_DEF;

  // Window slot indices, row-major, oldest row/column first.
  localparam int W_TL = 0;
  localparam int W_TM = 1;
  localparam int W_TR = 2;
  localparam int W_ML = 3;
  localparam int W_MM = 4;
  localparam int W_MR = 5;
  localparam int W_BL = 6;
  localparam int W_BM = 7;
  localparam int W_BR = 8;

  // Kernel weights used by the convolution stage.
  localparam int K_CORNER = 4;
  localparam int K_EDGE   = 3;
  localparam int K_CENTRE = 4;

endpackage

// File: rtl/img_line_buf.sv
// One image row of storage: DEPTH x DW single-port array.
// Read is combinational (old contents visible the same cycle as the write),
// write is registered. Contents are never reset.
//   clk     : clock
//   we_i    : write enable
//   addr_i  : shared read/write address (column)
//   wdata_i : write data
//   rdata_o : combinational read data at addr_i
module img_line_buf #(
  parameter int DEPTH = 512,
  parameter int DW    = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/img_win_gen.sv
// 3x3 sliding-window generator. Takes a raster pixel stream and emits every
// fully-interior 3x3 window ((IMG_W-2)*(IMG_H-2) per frame) on a valid/ready
// output, one cycle after the window's bottom-right pixel is accepted.
//   clk, rst    : clock, synchronous active-low reset
//   in_valid/in_ready/in_data    : pixel input handshake
//   win_valid/win_ready/win_data : window output handshake, w[k] at [k*DW +: DW]
//   win_last    : marks the final window of a frame
//   frame_done  : one-cycle pulse after the frame's last pixel is accepted
module img_win_gen
  import img_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*DW-1:0] win_data,
  output logic            win_last,
  output logic            frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [8:0][DW-1:0]    win_q, win_d;
  logic [9*DW-1:0]       win_data_q;
  logic                  win_valid_q, win_last_q, frame_done_q;
  logic [DW-1:0]         top, mid;
  logic                  acc, last_pix, emit;

  // lb0 holds the previous row, lb1 the row before it; on accept the column
  // entry migrates lb0 -> lb1 and the new pixel lands in lb0.
  img_line_buf #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_lb0 (
    .clk(clk), .we_i(acc), .addr_i(col_q), .wdata_i(in_data), .rdata_o(mid)
  );
  img_line_buf #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_lb1 (
    .clk(clk), .we_i(acc), .addr_i(col_q), .wdata_i(mid), .rdata_o(top)
  );

  // Single output register: stall input only while a held window is refused.
  assign in_ready = !win_valid_q || win_ready;
  assign acc      = in_valid && in_ready;
  assign last_pix = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
  assign emit     = acc && (row_q >= RW'(2)) && (col_q >= CW'(2));

  always_comb begin
    win_d = win_q;
    col_d = col_q;
    row_d = row_q;
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3]   = win_q[r*3+1];
        win_d[r*3+1] = win_q[r*3+2];
      end
      win_d[W_TR] = top;
      win_d[W_MR] = mid;
      win_d[W_BR] = in_data;
      if (col_q == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_data_q   <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      frame_done_q <= acc && last_pix;
      // A take and a new emit in the same cycle keep valid high: 1 window/clk.
      if (emit) begin
        win_valid_q <= 1'b1;
        win_data_q  <= win_d;
        win_last_q  <= last_pix;
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
        win_last_q  <= 1'b0;
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign win_last   = win_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_img_win_gen.sv
module tb_img_win_gen;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 16;
  localparam int WW = 9 * DW;

  logic          clk, rst;
  logic          in_valid, in_ready, win_valid, win_ready, win_last, frame_done;
  logic [DW-1:0] in_data;
  logic [WW-1:0] win_data;

  img_win_gen #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_last(win_last), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a 2D copy of the current frame plus an expected-window queue.
  logic [DW-1:0] pix [H][W];
  logic [WW-1:0] expq[$];
  bit            lastq[$];
  int            m_r, m_c;
  bit            exp_vld, exp_fd, held, held_last;
  logic [WW-1:0] held_data;
  int            n_win, n_last, n_fd, n_inr_low;
  logic [WW-1:0] first_win, last_win;
  bit            first_seen;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] model_win(input int r, input int c);
    logic [WW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = pix[r-2+k/3][c-2+k%3];
    return w;
  endfunction

  // Window expected when pixel (r,c) carries off + r*16 + c.
  function automatic logic [WW-1:0] pwin(input int off, input int r, input int c);
    logic [WW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(off + (r-2+k/3)*16 + (c-2+k%3));
    return w;
  endfunction

  task automatic clr_stats();
    n_win = 0; n_last = 0; n_fd = 0; n_inr_low = 0; first_seen = 0;
    first_win = '0; last_win = '0;
  endtask

  // One clock: drive, check at negedge, update model, advance past posedge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit rdy, output bit acc);
    bit emit;
    logic [WW-1:0] ew;
    bit el;
    in_valid = v; in_data = d; win_ready = rdy;
    @(negedge clk);
    chk("win_valid", win_valid, exp_vld);
    chk("frame_done", frame_done, exp_fd);
    chk("in_ready", in_ready, !exp_vld || rdy);
    if (held) begin
      chk("hold_data", win_data, held_data);
      chk("hold_last", win_last, held_last);
    end
    if (frame_done) n_fd++;
    if (!in_ready) n_inr_low++;
    if (win_valid && rdy) begin
      if (expq.size() == 0) chk("spurious_win", win_valid, 0);
      else begin
        ew = expq.pop_front(); el = lastq.pop_front();
        chk("win_data", win_data, ew);
        chk("win_last", win_last, el);
      end
      if (!first_seen) first_win = win_data;
      first_seen = 1;
      if (win_last) begin last_win = win_data; n_last++; end
      n_win++;
    end
    acc  = v && in_ready;
    held = win_valid && !rdy;
    held_data = win_data; held_last = win_last;
    emit = 0; exp_fd = 0;
    if (acc) begin
      pix[m_r][m_c] = d;
      if (m_r >= 2 && m_c >= 2) begin
        expq.push_back(model_win(m_r, m_c));
        lastq.push_back(m_r == H-1 && m_c == W-1);
        emit = 1;
      end
      exp_fd = (m_r == H-1 && m_c == W-1);
      if (m_c == W-1) begin m_c = 0; m_r = (m_r == H-1) ? 0 : m_r + 1; end
      else m_c++;
    end
    exp_vld = emit || held;
    @(posedge clk); #1;
  endtask

  // Feed npix pixels; pat selects off+r*16+c data, otherwise random.
  task automatic stream(input int npix, input bit pat, input int off,
                        input int vpct, input int rpct, input bit stall_first);
    int left = npix;
    int budget = 0;
    int stall = 0;
    bit stalled = 0;
    bit acc, v, r;
    logic [DW-1:0] d;
    d = pat ? DW'(off + m_r*16 + m_c) : DW'($urandom);
    while (left > 0 && budget < 5000) begin
      v = ($urandom_range(99) < vpct);
      r = ($urandom_range(99) < rpct);
      if (stall_first && !stalled && win_valid) begin stall = 4; stalled = 1; end
      if (stall > 0) begin r = 0; stall--; end
      cyc(v, d, r, acc);
      if (acc) begin
        left--;
        d = pat ? DW'(off + m_r*16 + m_c) : DW'($urandom);
      end
      budget++;
    end
    chk("stream_pixels_left", left, 0);
  endtask

  task automatic drain();
    int b = 0;
    bit acc;
    while ((expq.size() > 0 || exp_vld) && b < 50) begin
      cyc(0, '0, 1, acc); b++;
    end
    cyc(0, '0, 1, acc);
    cyc(0, '0, 1, acc);
    chk("drain_queue_empty", expq.size(), 0);
  endtask

  task automatic do_reset();
    in_valid = 0; in_data = '0; win_ready = 0; rst = 0;
    @(posedge clk); #1;
    rst = 1;
    m_r = 0; m_c = 0; expq.delete(); lastq.delete();
    exp_vld = 0; exp_fd = 0; held = 0;
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_last", win_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_win_data", win_data, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    rst = 0; in_valid = 0; in_data = '0; win_ready = 0;
    do_reset();

    // Full-rate frame with pattern data.
    clr_stats();
    stream(W*H, 1, 0, 100, 100, 0);
    drain();
    chk("t1_n_win", n_win, 6);
    chk("t1_n_last", n_last, 1);
    chk("t1_n_fd", n_fd, 1);
    chk("t1_in_ready_low", n_inr_low, 0);
    chk("t1_first_win", first_win, pwin(0, 2, 2));
    chk("t1_last_win", last_win, pwin(0, 3, 4));

    // Downstream refuses the first window for 4 clocks.
    clr_stats();
    stream(W*H, 1, 0, 100, 100, 1);
    drain();
    chk("t2_n_win", n_win, 6);
    chk("t2_in_ready_low", n_inr_low, 4);
    chk("t2_first_win", first_win, pwin(0, 2, 2));
    chk("t2_n_last", n_last, 1);

    // Random bubbles and random backpressure, random data.
    for (int f = 0; f < 4; f++) begin
      clr_stats();
      stream(W*H, 0, 0, 60, 55, 0);
      drain();
      chk("t3_n_win", n_win, 6);
      chk("t3_n_last", n_last, 1);
      chk("t3_n_fd", n_fd, 1);
    end

    // Reset after pixel (2,3), then a fresh frame.
    stream(2*W+4, 0, 0, 100, 100, 0);
    do_reset();
    clr_stats();
    stream(W*H, 1, 'h100, 100, 100, 0);
    drain();
    chk("t4_n_win", n_win, 6);
    chk("t4_first_win", first_win, pwin('h100, 2, 2));
    chk("t4_last_win", last_win, pwin('h100, 3, 4));

    // Two frames back-to-back, then two more with random flow control.
    clr_stats();
    stream(2*W*H, 0, 0, 100, 100, 0);
    drain();
    chk("t5_n_win", n_win, 12);
    chk("t5_n_last", n_last, 2);
    chk("t5_n_fd", n_fd, 2);
    clr_stats();
    stream(2*W*H, 0, 0, 80, 70, 0);
    drain();
    chk("t6_n_win", n_win, 12);
    chk("t6_n_last", n_last, 2);
    chk("t6_n_fd", n_fd, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
